// File: rtl/vga_pixel_fetch.sv
// Raster tracker and framebuffer reader: turns sync-generator blank/HS/VS into 24-bit pixels.
// Latency: an input sampled at posedge t appears on vga_* at posedge t+RD_LAT+2.
// Backpressure: none; the RAM must accept a read every cycle, and the output streams at the pixel rate.
//
// Ports:
//   vga_clk, reset_n                  pixel clock (posedge) and async active-low reset
//   blank_n_in, hs_in, vs_in          raw timing from the sync generator
//   fb_rd_en, fb_rd_addr, fb_rd_data  framebuffer read port (data RD_LAT cycles after the strobe)
//   vga_r/g/b, vga_hs, vga_vs, vga_blank_n  aligned pixel stream
//   frame_start                       one-cycle pulse on each vs high-to-low transition
module vga_pixel_fetch #(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int SCALE     = 4,
  parameter int ADDR_W    = 15,
  parameter int RD_LAT    = 2
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              blank_n_in,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [5:0]        fb_rd_data,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic              frame_start
);

  localparam int X_MAX = FB_WIDTH * SCALE;
  localparam int Y_MAX = FB_HEIGHT * SCALE;
  localparam int SX_W  = $clog2(X_MAX) + 2;
  localparam int SY_W  = $clog2(Y_MAX) + 2;
  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int FX_W  = $clog2(FB_WIDTH) + 1;
  localparam int DLY   = RD_LAT + 2;

  localparam logic [SX_W-1:0]   SX_LIM    = SX_W'(X_MAX);
  localparam logic [SX_W-1:0]   SX_SAT    = '1;
  localparam logic [SY_W-1:0]   SY_LIM    = SY_W'(Y_MAX);
  localparam logic [SY_W-1:0]   SY_SAT    = '1;
  localparam logic [SUB_W-1:0]  SUB_TOP   = SUB_W'(SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(FB_WIDTH);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((FB_HEIGHT - 1) * FB_WIDTH);

  typedef enum logic {UNSYNCED, SYNCED} sync_state_t;
  sync_state_t state, state_nxt;

  logic              blank_r, hs_r, vs_r;
  logic [DLY-1:0]    blank_d, hs_d, vs_d;
  logic [SX_W-1:0]   sx;
  logic [SUB_W-1:0]  sub_x;
  logic [FX_W-1:0]   fx;
  logic [SY_W-1:0]   sy;
  logic [SUB_W-1:0]  sub_y;
  logic [ADDR_W-1:0] line_base;
  logic [RD_LAT-1:0] vld_d;
  logic              run_x, line_end, rd_req;
  logic [7:0]        r_nxt, g_nxt, b_nxt;

  // vs low overrides a (malformed) high blank_n: the x counters stay cleared.
  assign run_x    = blank_r & vs_r;
  // blank_d[0] is the previous sample of blank_n.
  assign line_end = blank_d[0] & ~blank_r;

  assign vga_blank_n = blank_d[DLY-1];
  assign vga_hs      = hs_d[DLY-1];
  assign vga_vs      = vs_d[DLY-1];

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_r <= 1'b0;
      hs_r    <= 1'b1;
      vs_r    <= 1'b1;
      blank_d <= '0;
      hs_d    <= '1;
      vs_d    <= '1;
    end else begin
      blank_r <= blank_n_in;
      hs_r    <= hs_in;
      vs_r    <= vs_in;
      blank_d <= {blank_d[DLY-2:0], blank_r};
      hs_d    <= {hs_d[DLY-2:0], hs_r};
      vs_d    <= {vs_d[DLY-2:0], vs_r};
    end
  end

  // Horizontal position; sx saturates so an endless blank_n high never wraps back into range.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sx    <= '0;
      sub_x <= '0;
      fx    <= '0;
    end else if (!run_x) begin
      sx    <= '0;
      sub_x <= '0;
      fx    <= '0;
    end else begin
      if (sx != SX_SAT) sx <= sx + SX_W'(1);
      if (sub_x == SUB_TOP) begin
        sub_x <= '0;
        fx    <= fx + FX_W'(1);
      end else begin
        sub_x <= sub_x + SUB_W'(1);
      end
    end
  end

  // Vertical position; line_base tracks fy*FB_WIDTH by addition and stops at the last row.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sy        <= '0;
      sub_y     <= '0;
      line_base <= '0;
    end else if (!vs_r) begin
      sy        <= '0;
      sub_y     <= '0;
      line_base <= '0;
    end else if (line_end) begin
      if (sy != SY_SAT) sy <= sy + SY_W'(1);
      if (sub_y == SUB_TOP) begin
        sub_y <= '0;
        if (line_base != LAST_BASE) line_base <= line_base + ROW_STEP;
      end else begin
        sub_y <= sub_y + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) state <= UNSYNCED;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    if (!vs_r) state_nxt = SYNCED;
    rd_req = (state == SYNCED) && run_x && (sx < SX_LIM) && (sy < SY_LIM);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_rd_en    <= 1'b0;
      fb_rd_addr  <= '0;
      vld_d       <= '0;
      frame_start <= 1'b0;
    end else begin
      fb_rd_en    <= rd_req;
      if (rd_req) fb_rd_addr <= line_base + ADDR_W'(fx);
      // vld_d[RD_LAT-1] lines up with fb_rd_data being valid.
      vld_d       <= (vld_d << 1) | RD_LAT'(fb_rd_en);
      frame_start <= vs_d[0] & ~vs_r;
    end
  end

  // Each 2-bit channel is replicated to 8 bits so 2'b11 maps to full scale.
  always_comb begin
    r_nxt = 8'h00;
    g_nxt = 8'h00;
    b_nxt = 8'h00;
    if (vld_d[RD_LAT-1] && blank_d[RD_LAT]) begin
      r_nxt = {4{fb_rd_data[5:4]}};
      g_nxt = {4{fb_rd_data[3:2]}};
      b_nxt = {4{fb_rd_data[1:0]}};
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_r <= 8'h00;
      vga_g <= 8'h00;
      vga_b <= 8'h00;
    end else begin
      vga_r <= r_nxt;
      vga_g <= g_nxt;
      vga_b <= b_nxt;
    end
  end

endmodule
